// File: rtl/cmp_search_if.sv
// Bundle between the search controller and the external magnitude comparator.
// master = controller side, slave = comparator/requester side.
interface cmp_search_if #(
   parameter int WIDTH = 8,
   parameter int CW    = 4
);
   logic             start;
   logic             a_eq_b;
   logic             a_gr_b;
   logic             a_ls_b;
   logic [WIDTH-1:0] guess;
   logic             busy;
   logic             done;
   logic             found;
   logic             err;
   logic [WIDTH-1:0] result;
   logic [CW-1:0]    probes;

   modport master (
      input  start, a_eq_b, a_gr_b, a_ls_b,
      output guess, busy, done, found, err, result, probes
   );

   modport slave (
      output start, a_eq_b, a_gr_b, a_ls_b,
      input  guess, busy, done, found, err, result, probes
   );
endinterface

// File: rtl/cmp_search_ctrl.sv
// Binary search for the hidden operand of a compare-only port: drives guess,
// narrows [lo,hi] from the comparator flags, reports result/found/err/probes.
module cmp_search_ctrl #(
   parameter int WIDTH = 8,
   parameter int CW    = 4
) (
   input  logic         clk,
   input  logic         rst,
   cmp_search_if.master bus,
   output logic         o_state_dbg
);
   typedef enum logic {S_IDLE = 1'b0, S_PROBE = 1'b1} state_t;

   localparam logic [WIDTH-1:0] ALL_ONES  = '1;
   localparam logic [WIDTH-1:0] MID_START = ALL_ONES >> 1;
   localparam logic [WIDTH-1:0] ONE_W     = 1;
   localparam logic [WIDTH:0]   ONE_S     = 1;
   localparam logic [CW-1:0]    ONE_C     = 1;
   localparam logic [CW-1:0]    PROBE_MAX = CW'(WIDTH + 1);

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_lo, r_hi, r_guess, r_result;
   logic [WIDTH-1:0] w_lo_nxt, w_hi_nxt, w_guess_nxt, w_result_nxt;
   logic             r_done, r_found, r_err;
   logic             w_done_nxt, w_found_nxt, w_err_nxt;
   logic [CW-1:0]    r_probes, w_probes_nxt;

   logic [2:0]       w_flags;
   logic             w_legal, w_at_limit, w_term;
   logic [WIDTH:0]   w_sum_dn, w_sum_up;

   // Handshake: start is a request sampled only while idle; a request seen
   // while busy (including the done edge) is dropped, never queued.
   assign w_flags    = {bus.a_eq_b, bus.a_gr_b, bus.a_ls_b};
   assign w_legal    = $onehot(w_flags);
   assign w_at_limit = (r_probes == PROBE_MAX);

   // Midpoints carried in WIDTH+1 bits so lo+hi cannot overflow at hi=all-ones.
   assign w_sum_dn = {1'b0, r_lo} + {1'b0, r_guess} - ONE_S;
   assign w_sum_up = {1'b0, r_guess} + ONE_S + {1'b0, r_hi};

   assign w_term = !w_legal || bus.a_eq_b || w_at_limit ||
                   (bus.a_gr_b && (r_guess == r_lo)) ||
                   (bus.a_ls_b && (r_guess == r_hi));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_lo     <= '0;
         r_hi     <= ALL_ONES;
         r_guess  <= '0;
         r_result <= '0;
         r_done   <= 1'b0;
         r_found  <= 1'b0;
         r_err    <= 1'b0;
         r_probes <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_lo     <= w_lo_nxt;
         r_hi     <= w_hi_nxt;
         r_guess  <= w_guess_nxt;
         r_result <= w_result_nxt;
         r_done   <= w_done_nxt;
         r_found  <= w_found_nxt;
         r_err    <= w_err_nxt;
         r_probes <= w_probes_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_state_nxt = S_PROBE;
         S_PROBE: if (w_term)    w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_lo_nxt     = r_lo;
      w_hi_nxt     = r_hi;
      w_guess_nxt  = r_guess;
      w_result_nxt = r_result;
      w_done_nxt   = 1'b0;
      w_found_nxt  = r_found;
      w_err_nxt    = r_err;
      w_probes_nxt = r_probes;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_lo_nxt     = '0;
               w_hi_nxt     = ALL_ONES;
               w_guess_nxt  = MID_START;
               w_probes_nxt = ONE_C;
               w_found_nxt  = 1'b0;
               w_err_nxt    = 1'b0;
               w_result_nxt = '0;
            end
         end
         S_PROBE: begin
            if (!w_legal) begin
               w_err_nxt  = 1'b1;
               w_done_nxt = 1'b1;
            end else if (bus.a_eq_b) begin
               w_result_nxt = r_guess;
               w_found_nxt  = 1'b1;
               w_done_nxt   = 1'b1;
            end else if (w_at_limit) begin
               w_found_nxt = 1'b0;
               w_done_nxt  = 1'b1;
            end else if (bus.a_gr_b) begin
               if (r_guess == r_lo) begin
                  w_found_nxt = 1'b0;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_hi_nxt     = r_guess - ONE_W;
                  w_guess_nxt  = w_sum_dn[WIDTH:1];
                  w_probes_nxt = r_probes + ONE_C;
               end
            end else begin
               if (r_guess == r_hi) begin
                  w_found_nxt = 1'b0;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_lo_nxt     = r_guess + ONE_W;
                  w_guess_nxt  = w_sum_up[WIDTH:1];
                  w_probes_nxt = r_probes + ONE_C;
               end
            end
         end
         default: ;
      endcase
   end

   assign bus.guess   = r_guess;
   assign bus.busy    = (r_state == S_PROBE);
   assign bus.done    = r_done;
   assign bus.found   = r_found;
   assign bus.err     = r_err;
   assign bus.result  = r_result;
   assign bus.probes  = r_probes;
   assign o_state_dbg = r_state;
endmodule

// File: tb/tb_cmp_search_ctrl.sv
// Directed bench for cmp_search_ctrl: a behavioural binary-search model fills
// the expected guess queue and final status; one negedge process compares.
module tb_cmp_search_ctrl;
  localparam int WIDTH = 8;
  localparam int CW    = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic state_dbg;
  always #5 clk = ~clk;

  cmp_search_if #(.WIDTH(WIDTH), .CW(CW)) bus ();

  cmp_search_ctrl #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.master),
    .o_state_dbg (state_dbg)
  );

  // ---------------- comparator model (stimulus) ----------------
  logic [WIDTH-1:0] b_val;
  int               mode;     // 0 honest, 1 all flags low on probe fault_n, 2 stuck a_gr_b
  int               fault_n;

  always_comb begin
    bus.a_eq_b = 1'b0;
    bus.a_gr_b = 1'b0;
    bus.a_ls_b = 1'b0;
    if (mode == 2) begin
      bus.a_gr_b = 1'b1;
    end else if (!(mode == 1 && int'(bus.probes) == fault_n)) begin
      bus.a_eq_b = (bus.guess == b_val);
      bus.a_gr_b = (bus.guess >  b_val);
      bus.a_ls_b = (bus.guess <  b_val);
    end
  end

  // ---------------- scoreboard ----------------
  logic [WIDTH-1:0] exp_q[$];
  logic             exp_found, exp_err;
  logic [WIDTH-1:0] exp_result;
  int               exp_probes;
  logic             exp_active;
  int               done_cnt;
  int               checks;
  int               errors;
  logic [WIDTH-1:0] cmp_g;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Plain-integer binary search over [0, 2^WIDTH-1] following the flag rules.
  task automatic build_model(input int bv, input int md, input int fn);
    int lo, hi, g, n;
    lo = 0;
    hi = (1 << WIDTH) - 1;
    n  = 0;
    exp_q.delete();
    exp_found  = 1'b0;
    exp_err    = 1'b0;
    exp_result = '0;
    forever begin
      g = (lo + hi) / 2;
      n++;
      exp_q.push_back(g[WIDTH-1:0]);
      if (md == 1 && n == fn) begin exp_err = 1'b1; break; end
      if (md != 2 && g == bv) begin
        exp_found  = 1'b1;
        exp_result = g[WIDTH-1:0];
        break;
      end
      if (n == WIDTH + 1) break;
      if (md == 2 || g > bv) begin
        if (g == lo) break;
        hi = g - 1;
      end else begin
        if (g == hi) break;
        lo = g + 1;
      end
    end
    exp_probes = n;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.busy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL busy_extra: busy=1 with no probe expected (t=%0t)", $time);
        end else begin
          cmp_g = exp_q.pop_front();
          checks--;
          check("guess", int'(bus.guess), int'(cmp_g));
        end
      end
      if (bus.done) begin
        if (!exp_active) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected: done=1 with no search pending (t=%0t)", $time);
        end else begin
          check("done_queue_left", exp_q.size(), 0);
          check("done_busy", int'(bus.busy), 0);
          check("found", int'(bus.found), int'(exp_found));
          check("err", int'(bus.err), int'(exp_err));
          check("result", int'(bus.result), int'(exp_result));
          check("probes", int'(bus.probes), exp_probes);
          exp_active = 1'b0;
          done_cnt++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_search();
    @(negedge clk);
    exp_active = 1'b1;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int base;
    bit got;
    base = done_cnt;
    got  = 1'b0;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      #1;
      if (done_cnt != base) got = 1'b1;
    end
    check({name, "_timeout"}, int'(got), 1);
  endtask

  task automatic pin_seq(input string name, input int seq[], input int n);
    check({name, "_len"}, exp_q.size(), n);
    for (int i = 0; i < n && i < exp_q.size(); i++)
      check(name, int'(exp_q[i]), seq[i]);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int seq0[] = '{127, 63, 31, 15, 7, 3, 1, 0};
    int seq255[] = '{127, 191, 223, 239, 247, 251, 253, 254, 255};
    checks     = 0;
    errors     = 0;
    done_cnt   = 0;
    exp_active = 1'b0;
    rst        = 1'b1;
    bus.start  = 1'b0;
    mode       = 0;
    fault_n    = 0;
    b_val      = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_guess",  int'(bus.guess), 0);
    check("rst_busy",   int'(bus.busy), 0);
    check("rst_done",   int'(bus.done), 0);
    check("rst_found",  int'(bus.found), 0);
    check("rst_err",    int'(bus.err), 0);
    check("rst_result", int'(bus.result), 0);
    check("rst_probes", int'(bus.probes), 0);
    check("rst_state",  int'(state_dbg), 0);

    // b = 127: first guess hits
    b_val = 8'd127;
    build_model(127, 0, 0);
    check("model127_probes", exp_probes, 1);
    start_search();
    wait_done("t127");
    check("t127_result", int'(bus.result), 127);
    check("t127_probes", int'(bus.probes), 1);

    // b = 0: walk to the bottom
    b_val = 8'd0;
    build_model(0, 0, 0);
    pin_seq("model0_seq", seq0, 8);
    start_search();
    wait_done("t0");
    check("t0_found", int'(bus.found), 1);

    // b = 255: upper bound, nine probes
    b_val = 8'd255;
    build_model(255, 0, 0);
    pin_seq("model255_seq", seq255, 9);
    start_search();
    wait_done("t255");
    check("t255_probes", int'(bus.probes), 9);

    // illegal all-zero flags on third probe, then a clean rerun
    b_val   = 8'd100;
    mode    = 1;
    fault_n = 3;
    build_model(100, 1, 3);
    check("model_err_probes", exp_probes, 3);
    start_search();
    wait_done("terr");
    check("terr_err", int'(bus.err), 1);
    mode = 0;
    build_model(100, 0, 0);
    start_search();
    wait_done("t100");
    check("t100_err", int'(bus.err), 0);
    check("t100_result", int'(bus.result), 100);

    // stuck a_gr_b with extra start pulses while busy
    mode = 2;
    build_model(0, 2, 0);
    check("model_stuck_probes", exp_probes, 8);
    start_search();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("tstuck");
    check("tstuck_found", int'(bus.found), 0);
    mode = 0;

    // b = 200: reset during the fourth probe, then restart
    b_val = 8'd200;
    build_model(200, 0, 0);
    start_search();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    exp_active = 1'b0;
    @(negedge clk);
    check("abort_guess",  int'(bus.guess), 0);
    check("abort_busy",   int'(bus.busy), 0);
    check("abort_done",   int'(bus.done), 0);
    check("abort_probes", int'(bus.probes), 0);
    check("abort_state",  int'(state_dbg), 0);
    repeat (2) @(negedge clk);
    build_model(200, 0, 0);
    check("model200_probes", exp_probes, 8);
    start_search();
    wait_done("t200");
    check("t200_result", int'(bus.result), 200);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cmp_search_ctrl.md
Name: cmp_search_ctrl

Overview:
- Initiator side of the magnitude-comparator interface: drives candidate value `guess` into an external comparator as operand a.
- The comparator holds an unknown operand b. The block consumes the comparator's a_eq_b/a_gr_b/a_ls_b flags and binary-searches for b.
- Used to recover a register/threshold value through a compare-only port; reports result, found/err status and probe count.

Parameters:
- WIDTH, 8, operand width of guess/result and of the external comparator.
- CW, 4, width of probe counter; must hold WIDTH+1.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a new search; sampled only in IDLE
- a_eq_b  in  1  comparator flag: guess == b (combinational response to current guess)
- a_gr_b  in  1  comparator flag: guess > b
- a_ls_b  in  1  comparator flag: guess < b
- guess  out  WIDTH  registered candidate driven to comparator operand a
- busy  out  1  high while in PROBE
- done  out  1  one-cycle pulse on search termination
- found  out  1  last search ended on a_eq_b
- err  out  1  last search ended on an illegal flag combination
- result  out  WIDTH  matched value (valid when found=1)
- probes  out  CW  number of probe cycles used by last/current search

Behaviour:
- Reset (sync, rst=1 at edge): state=IDLE; guess=0, busy=0, done=0, found=0, err=0, result=0, probes=0; lo=0, hi=all-ones. Reset mid-search aborts immediately, no done pulse.
- States: IDLE, PROBE.
- IDLE, start=1 at edge:
  - lo=0, hi=2^WIDTH-1, guess=(lo+hi)>>1 = 2^(WIDTH-1)-1.
  - probes=1, found=0, err=0, result=0.
  - Next state PROBE.
- IDLE, start=0: all outputs hold. done is forced 0 on every edge except the terminating one.
- PROBE, each edge evaluates the flags against the current guess (comparator is combinational, so one probe per cycle). Exactly one flag must be high.
  - Legal: the flags are one-hot.
  - Illegal: zero flags or more than one flag high → err=1, done=1, state=IDLE. Checked before any other condition.
  - a_eq_b → result=guess, found=1, done=1, state=IDLE.
  - a_gr_b:
    - if guess==lo → found=0, done=1, IDLE (not found);
    - else hi=guess-1, guess=(lo+guess-1)>>1, probes+1.
  - a_ls_b:
    - if guess==hi → found=0, done=1, IDLE;
    - else lo=guess+1, guess=(guess+1+hi)>>1, probes+1.
- Arithmetic rules:
  - Midpoint sum is computed in WIDTH+1 bits, so there is no overflow at hi=all-ones.
  - guess-1 is never evaluated when guess==lo, and guess+1 never when guess==hi, so there is no wrap.
- Probe limit: if probes==WIDTH+1 and the flag is not a_eq_b → terminate not-found (done=1, found=0, err=0). This is a safety bound; a consistent comparator always hits eq within WIDTH+1 probes.
- Output holding:
  - guess holds its last value in IDLE.
  - result/found/err/probes hold until the next accepted start.
- busy=1 exactly while state=PROBE. done and the state→IDLE transition occur on the same edge, so done is high the cycle after the last probe, with busy=0.
- start while busy: ignored. start on the same edge done asserts is also ignored (state was PROBE); start is accepted the following cycle.
- Latency: start edge → first probe cycle; done at edge N+1 after start, where N=probes (1..WIDTH+1).

Test Plan:
- WIDTH=8, b=127, pulse start → guess=127 in first PROBE cycle; next cycle done=1, found=1, result=127, probes=1, busy=0.
- b=0 → guess sequence 127,63,31,15,7,3,1,0; done with found=1, result=0, probes=8.
- b=255 → guess sequence 127,191,223,239,247,251,253,254,255; found=1, result=255, probes=9 (upper-bound case, no midpoint overflow).
- Comparator forced to output all flags 0 on the 3rd probe → done=1, err=1, found=0, probes=3; assert start again → err/found clear, new search runs normally.
- Comparator stuck at a_gr_b=1 → hi walks down to lo=0, guess==lo → done=1, found=0, err=0; start pulses during busy are ignored (probes unaffected).
- b=200, assert rst on the 4th PROBE cycle → next cycle all outputs 0, IDLE, no done pulse; restart finds result=200.
